chess_time_display: RTL and testbench



---
 rtl/chess_time_display.sv | 203 ++++++++++++++++++++
 tb/tb_chess_time_display.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/chess_time_display.sv
// chess_time_display
// Converts both players' remaining seconds into MM:SS BCD with a small
// subtract-based converter, then scans the two times across an 8-digit
// active-low seven-segment display (P1 on the left four digits, P2 on the
// right four). The active player's minutes-ones digit lights its decimal point.
`timescale 1ns/1ps

module chess_time_display #(
    parameter int SCAN_DIV    = 50000,
    parameter int MAX_SECONDS = 5999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] player1_time,
    input  logic [15:0] player2_time,
    input  logic        player1_flag,
    input  logic        player2_flag,
    output logic [15:0] p1_bcd,
    output logic [15:0] p2_bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV60,
        S_SPLIT,
        S_COMMIT
    } state_t;

    // ---------------- converter ----------------
    state_t      state_q;
    logic        sel_q;            // 0 = converting P1, 1 = converting P2
    logic [12:0] rem_q;            // seconds left to split
    logic [6:0]  min_q;            // whole minutes extracted so far
    logic [3:0]  sec_tens_q;
    logic [3:0]  min_tens_q;
    logic [15:0] p1_bcd_q;
    logic [15:0] p2_bcd_q;
    logic        bcd_valid_q;

    logic [15:0] time_sel;
    logic [12:0] load_val;

    // Pick the player being loaded and clamp the time to 99:59
    always_comb begin
        time_sel = sel_q ? player2_time : player1_time;
        if (time_sel > 16'(MAX_SECONDS)) begin
            load_val = 13'(MAX_SECONDS);
        end else begin
            load_val = time_sel[12:0];
        end
    end

    // Converter FSM: IDLE -> P1 conversion -> P2 conversion -> IDLE, forever
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            rem_q       <= '0;
            min_q       <= '0;
            sec_tens_q  <= '0;
            min_tens_q  <= '0;
            p1_bcd_q    <= '0;
            p2_bcd_q    <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sel_q   <= 1'b0;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    rem_q      <= load_val;
                    min_q      <= '0;
                    sec_tens_q <= '0;
                    min_tens_q <= '0;
                    state_q    <= S_DIV60;
                end
                S_DIV60: begin
                    if (rem_q >= 13'd60) begin
                        rem_q <= rem_q - 13'd60;
                        min_q <= min_q + 7'd1;
                    end else begin
                        state_q <= S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    // seconds and minutes are split into tens/ones in parallel
                    if (rem_q >= 13'd10) begin
                        rem_q      <= rem_q - 13'd10;
                        sec_tens_q <= sec_tens_q + 4'd1;
                    end
                    if (min_q >= 7'd10) begin
                        min_q      <= min_q - 7'd10;
                        min_tens_q <= min_tens_q + 4'd1;
                    end
                    if ((rem_q < 13'd10) && (min_q < 7'd10)) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (!sel_q) begin
                        p1_bcd_q <= {min_tens_q, min_q[3:0], sec_tens_q, rem_q[3:0]};
                        sel_q    <= 1'b1;
                        state_q  <= S_LOAD;
                    end else begin
                        p2_bcd_q    <= {min_tens_q, min_q[3:0], sec_tens_q, rem_q[3:0]};
                        bcd_valid_q <= 1'b1;
                        sel_q       <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------- display scan ----------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          tick;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [6:0]    seg_d;
    logic          dp_d;

    logic [31:0]   disp_word;
    logic [3:0]    digit_w [8];

    assign disp_word = {p1_bcd_q, p2_bcd_q};

    // Digit i of the display maps to nibble i of {p1_bcd, p2_bcd}
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign digit_w[gi] = disp_word[gi*4 +: 4];
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan counter and next digit; segments/dp computed for the next digit
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 3'd1 : idx_q;
        seg_d = seg_decode(digit_w[idx_d]);
        dp_d  = ~(((idx_d == 3'd6) && player1_flag) || ((idx_d == 3'd2) && player2_flag));
    end

    // an/seg/dp move together with the digit index so they never disagree
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFE;
            seg_q <= 7'b1000000;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            if (tick) begin
                idx_q <= idx_d;
                an_q  <= ~(8'b1 << idx_d);
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end
        end
    end

    assign p1_bcd    = p1_bcd_q;
    assign p2_bcd    = p2_bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;

endmodule

// File: tb/tb_chess_time_display.sv
// Directed bench for chess_time_display with a queue-based scoreboard of
// expected {p1_bcd, p2_bcd} per bcd_valid pulse, plus latency and scan checks.
`timescale 1ns/1ps

module tb_chess_time_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] player1_time = 16'd0;
    logic [15:0] player2_time = 16'd0;
    logic        player1_flag = 1'b0;
    logic        player2_flag = 1'b0;
    logic [15:0] p1_bcd;
    logic [15:0] p2_bcd;
    logic        bcd_valid;
    logic        busy;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    chess_time_display #(.SCAN_DIV(4), .MAX_SECONDS(5999)) dut (
        .clk          (clk),
        .reset        (reset),
        .player1_time (player1_time),
        .player2_time (player2_time),
        .player1_flag (player1_flag),
        .player2_flag (player2_flag),
        .p1_bcd       (p1_bcd),
        .p2_bcd       (p2_bcd),
        .bcd_valid    (bcd_valid),
        .busy         (busy),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called on a bcd_valid cycle: pop the oldest expectation and compare
    task automatic pop_compare(input string tag);
        logic [31:0] e;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_p1"}, {16'd0, p1_bcd}, {16'd0, e[31:16]});
            check({tag, "_p2"}, {16'd0, p2_bcd}, {16'd0, e[15:0]});
            check({tag, "_busy"}, {31'd0, busy}, 32'd0);
            $display("txn %s: p1_bcd=%h p2_bcd=%h exp=%h", tag, p1_bcd, p2_bcd, e);
        end
    endtask

    // Wait (bounded) for the next bcd_valid pulse, then score it
    task automatic wait_valid(input string tag, input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bcd_valid !== 1'b1 && cycles < limit);
        check({tag, "_valid_seen"}, {31'd0, bcd_valid}, 32'd1);
        if (bcd_valid === 1'b1) pop_compare(tag);
    endtask

    logic [6:0] seg_tab [8];
    int         cyc;
    int         p1_seen;
    logic [7:0] prev_an;
    logic [7:0] exp_an;
    logic       exp_dp;
    logic       f1, f2;
    int         idx;

    initial begin
        // expected segments for p1=12:34, p2=59:59, by digit index 0..7
        seg_tab[0] = 7'b0010000; seg_tab[1] = 7'b0010010;
        seg_tab[2] = 7'b0010000; seg_tab[3] = 7'b0010010;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0110000;
        seg_tab[6] = 7'b0100100; seg_tab[7] = 7'b1111001;

        // ---- reset held 3 cycles ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_p1", {16'd0, p1_bcd}, 32'd0);
            check("rst_p2", {16'd0, p2_bcd}, 32'd0);
            check("rst_valid", {31'd0, bcd_valid}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_an", {24'd0, an}, 32'h0000_00FE);
            check("rst_seg", {25'd0, seg}, 32'h0000_0040);
            check("rst_dp", {31'd0, dp}, 32'd1);
        end
        reset = 1'b0;
        exp_q.push_back({16'h0000, 16'h0000});
        wait_valid("first", 100, cyc);
        check("first_latency", 32'(cyc), 32'd9);

        // ---- 125 / 3599, with P1 latency and full-pass period ----
        player1_time = 16'd125;
        player2_time = 16'd3599;
        exp_q.push_back({16'h0205, 16'h5959});
        cyc = 0;
        p1_seen = -1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_in_load", {31'd0, busy}, 32'd1);
            if (p1_seen < 0 && p1_bcd == 16'h0205) p1_seen = cyc;
        end while (bcd_valid !== 1'b1 && cyc < 200);
        check("p1_commit_latency", 32'(p1_seen), 32'd7);
        check("pass_period", 32'(cyc), 32'd75);
        check("t125_valid_seen", {31'd0, bcd_valid}, 32'd1);
        if (bcd_valid === 1'b1) pop_compare("t125");

        // ---- input change during P1 DIV60 does not disturb this pass ----
        exp_q.push_back({16'h0205, 16'h5959});
        exp_q.push_back({16'h0059, 16'h5959});
        @(negedge clk);
        @(negedge clk);
        player1_time = 16'd59;
        wait_valid("mid_change", 200, cyc);
        wait_valid("after_change", 200, cyc);

        // ---- saturation ----
        player1_time = 16'hFFFF;
        player2_time = 16'd6000;
        exp_q.push_back({16'h9959, 16'h9959});
        wait_valid("saturate", 400, cyc);
        check("saturate_period", 32'(cyc), 32'd225);

        // ---- reset pulse during P2 SPLIT ----
        player1_time = 16'd59;
        player2_time = 16'd3599;
        repeat (73) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("midrst_p1", {16'd0, p1_bcd}, 32'd0);
        check("midrst_p2", {16'd0, p2_bcd}, 32'd0);
        check("midrst_valid", {31'd0, bcd_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_an", {24'd0, an}, 32'h0000_00FE);
        exp_q.push_back({16'h0059, 16'h5959});
        wait_valid("restart", 200, cyc);
        check("restart_latency", 32'(cyc), 32'd78);

        // ---- scan: p1 = 12:34, p2 = 59:59 ----
        player1_time = 16'd754;
        exp_q.push_back({16'h1234, 16'h5959});
        wait_valid("scan_setup", 200, cyc);
        cyc = 0;
        do begin
            prev_an = an;
            @(negedge clk);
            cyc++;
        end while (!(an == 8'hFE && prev_an != 8'hFE) && cyc < 100);
        check("scan_sync", {24'd0, an}, 32'h0000_00FE);
        for (int s = 0; s < 16; s++) begin
            idx = s % 8;
            if (s == 0) begin player1_flag = 1'b1; player2_flag = 1'b0; end
            if (s == 8) begin player1_flag = 1'b0; player2_flag = 1'b1; end
            f1 = (s < 8);
            f2 = (s >= 8);
            exp_an = ~(8'b1 << idx);
            exp_dp = ~(((idx == 6) && f1) || ((idx == 2) && f2));
            check("scan_an", {24'd0, an}, {24'd0, exp_an});
            check("scan_seg", {25'd0, seg}, {25'd0, seg_tab[idx]});
            check("scan_dp", {31'd0, dp}, {31'd0, exp_dp});
            $display("scan step %0d: an=%h seg=%b dp=%b", s, an, seg, dp);
            for (int c = 1; c < 4; c++) begin
                @(negedge clk);
                check("scan_hold", {24'd0, an}, {24'd0, exp_an});
            end
            @(negedge clk);
        end
        check("scan_wrap", {24'd0, an}, 32'h0000_00FE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
